i2c_target: RTL and testbench

//  Synthesizable I2C/SCCB target (responder): the other end of our camera-config I2C master.

---
 rtl/i2c_target.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C/SCCB target: filtered SCL/SDA sampling, START/STOP decode, register write/read port.
// Define I2C_TARGET_AUTOINC_EN to advance the register pointer after each data byte (burst access).
module i2c_target #(
  parameter logic [6:0] DEVICE_ADDR = 7'h21,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       scl_i,
  inout  wire        sda_io,
  output logic       wr_valid_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic [7:0] rd_addr_o,
  input  logic [7:0] rd_data_i,
  output logic       busy_o
);

`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic [1:0] w_line_in;
  logic [1:0] w_filt;
  logic [1:0] w_filt_d;

  assign w_line_in = {scl_i, sda_io};

  // Bit 1 = SCL, bit 0 = SDA: synchronize, then accept a new level only after FILTER_LEN stable cycles.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
      logic          r_s1, r_s2, r_f, r_fd;
      logic [CW-1:0] r_c;
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          r_s1 <= 1'b1;
          r_s2 <= 1'b1;
          r_f  <= 1'b1;
          r_fd <= 1'b1;
          r_c  <= '0;
        end else begin
          r_s1 <= w_line_in[gi];
          r_s2 <= r_s1;
          r_fd <= r_f;
          if (r_s2 != r_f) begin
            if (r_c == CW'(FILTER_LEN - 1)) begin
              r_f <= r_s2;
              r_c <= '0;
            end else begin
              r_c <= r_c + CW'(1);
            end
          end else begin
            r_c <= '0;
          end
        end
      end
      assign w_filt[gi]   = r_f;
      assign w_filt_d[gi] = r_fd;
    end
  endgenerate

  logic w_scl, w_sda, w_scl_d, w_sda_d;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl      = w_filt[1];
  assign w_sda      = w_filt[0];
  assign w_scl_d    = w_filt_d[1];
  assign w_sda_d    = w_filt_d[0];
  assign w_scl_rise = w_scl & ~w_scl_d;
  assign w_scl_fall = ~w_scl & w_scl_d;
  assign w_start    = w_scl & w_scl_d & w_sda_d & ~w_sda;
  assign w_stop     = w_scl & w_scl_d & ~w_sda_d & w_sda;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_phase;
  logic       r_sda_low;
  logic       r_wr_valid;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_busy;
  logic [7:0] w_byte;

  assign w_byte = {r_shift[6:0], w_sda};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_bit_cnt  <= 3'd7;
      r_shift    <= 8'h00;
      r_ptr      <= 8'h00;
      r_phase    <= 1'b0;
      r_sda_low  <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_stop) begin
        r_state   <= IDLE;
        r_sda_low <= 1'b0;
        r_phase   <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_start) begin
        r_state   <= DEV_ADDR;
        r_bit_cnt <= 3'd7;
        r_sda_low <= 1'b0;
        r_phase   <= 1'b0;
      end else begin
        case (r_state)
          DEV_ADDR, REG_ADDR, WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt - 3'd1;
              if (r_bit_cnt == 3'd0) begin
                r_phase <= 1'b0;
                if (r_state == DEV_ADDR) begin
                  if (w_byte[7:1] == DEVICE_ADDR) begin
                    r_state <= DEV_ACK;
                    r_busy  <= 1'b1;
                  end else begin
                    r_state <= WAIT_STOP;
                    r_busy  <= 1'b0;
                  end
                end else if (r_state == REG_ADDR) begin
                  r_ptr   <= w_byte;
                  r_state <= REG_ACK;
                end else begin
                  r_wr_valid <= 1'b1;
                  r_wr_addr  <= r_ptr;
                  r_wr_data  <= w_byte;
                  if (AUTOINC) r_ptr <= r_ptr + 8'd1;
                  r_state <= WR_ACK;
                end
              end
            end
          end
          // ACK is held low for one full SCL clock: asserted on the first fall, released on the next.
          DEV_ACK, REG_ACK, WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_low <= 1'b1;
                r_phase   <= 1'b1;
              end else begin
                r_phase   <= 1'b0;
                r_sda_low <= 1'b0;
                if (r_state == DEV_ACK) begin
                  if (r_shift[0]) begin
                    r_state   <= RD_DATA;
                    r_shift   <= rd_data_i;
                    r_sda_low <= ~rd_data_i[7];
                  end else begin
                    r_state <= REG_ADDR;
                  end
                end else begin
                  r_state <= WR_DATA;
                end
              end
            end
          end
          RD_DATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt - 3'd1;
              if (r_bit_cnt == 3'd0) r_phase <= 1'b1;
            end else if (w_scl_fall) begin
              if (r_phase) begin
                r_phase   <= 1'b0;
                r_sda_low <= 1'b0;
                r_state   <= RD_ACK;
              end else begin
                r_sda_low <= ~r_shift[6];
                r_shift   <= {r_shift[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_phase <= 1'b1;
                if (AUTOINC) r_ptr <= r_ptr + 8'd1;
              end else begin
                r_state <= WAIT_STOP;
                r_busy  <= 1'b0;
              end
            end else if (w_scl_fall && r_phase) begin
              r_phase   <= 1'b0;
              r_shift   <= rd_data_i;
              r_sda_low <= ~rd_data_i[7];
              r_state   <= RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_io     = r_sda_low ? 1'b0 : 1'bz;
  assign wr_valid_o = r_wr_valid;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;
  assign rd_addr_o  = r_ptr;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, write scoreboard, register-file model on the read port.
module tb_i2c_target;
  localparam int Q = 10;

`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AINC = 1'b1;
`else
  localparam bit AINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda_bus;
  logic       wr_valid;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       busy;
  int         checks = 0;
  int         failures = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;
  // Register-file model: read data is a fixed function of the address.
  assign rd_data = rd_addr ^ 8'h7C;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .scl_i     (scl),
    .sda_io    (sda_bus),
    .wr_valid_o(wr_valid),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .rd_addr_o (rd_addr),
    .rd_data_i (rd_data),
    .busy_o    (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(wr_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.a));
        check("wr_data", 32'(wr_data), 32'(mon_e.d));
      end
    end
  end

  task automatic qwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wbit(input logic v, input bit glitch);
    qwait(Q);
    m_low = ~v;
    qwait(Q);
    scl = 1'b1;
    if (glitch) begin
      qwait(Q / 2);
      scl = 1'b0;
      qwait(1);
      scl = 1'b1;
      qwait(Q + Q / 2 - 1);
    end else begin
      qwait(2 * Q);
    end
    scl = 1'b0;
  endtask

  task automatic rbit(output logic v);
    m_low = 1'b0;
    qwait(2 * Q);
    scl = 1'b1;
    qwait(Q);
    v = sda_bus;
    qwait(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_start;
    m_low = 1'b0;
    qwait(Q);
    scl = 1'b1;
    qwait(Q);
    m_low = 1'b1;
    qwait(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop;
    qwait(Q);
    m_low = 1'b1;
    qwait(Q);
    scl = 1'b1;
    qwait(Q);
    m_low = 1'b0;
    qwait(2 * Q);
  endtask

  // Returns the SDA level seen in the ninth clock (0 = ACK).
  task automatic wbyte(input logic [7:0] b, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(b[i], i == gbit);
    rbit(ack);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] b);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      rbit(v);
      b[i] = v;
    end
    wbit(nack, 1'b0);
  endtask

  task automatic rst_pulse(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check(tag, 32'(sda_bus), 32'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic       ack;
  logic [7:0] rb;

  initial begin
    qwait(4);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sda", 32'(sda_bus), 32'd1);
    rst = 1'b0;
    qwait(10);

    // Single write
    i2c_start();
    wbyte(8'h42, -1, ack); check("w1_dev_ack", 32'(ack), 32'd0);
    check("w1_busy", 32'(busy), 32'd1);
    wbyte(8'h12, -1, ack); check("w1_reg_ack", 32'(ack), 32'd0);
    exp_q.push_back('{a: 8'h12, d: 8'h80});
    wbyte(8'h80, -1, ack); check("w1_dat_ack", 32'(ack), 32'd0);
    i2c_stop();
    check("w1_busy_end", 32'(busy), 32'd0);

    // Wrong address
    i2c_start();
    wbyte(8'h44, -1, ack); check("bad_dev_nack", 32'(ack), 32'd1);
    check("bad_busy", 32'(busy), 32'd0);
    wbyte(8'h12, -1, ack); check("bad_reg_nack", 32'(ack), 32'd1);
    i2c_stop();

    // Read with repeated START and NACK
    i2c_start();
    wbyte(8'h42, -1, ack);
    wbyte(8'h0A, -1, ack);
    i2c_start();
    wbyte(8'h43, -1, ack); check("r1_dev_ack", 32'(ack), 32'd0);
    check("r1_rd_addr", 32'(rd_addr), 32'h0A);
    rbyte(1'b1, rb); check("r1_data", 32'(rb), 32'h76);
    check("r1_busy_nack", 32'(busy), 32'd0);
    i2c_stop();

    // Burst write
    i2c_start();
    wbyte(8'h42, -1, ack);
    wbyte(8'h10, -1, ack);
    exp_q.push_back('{a: 8'h10, d: 8'hAA});
    wbyte(8'hAA, -1, ack);
    exp_q.push_back('{a: (AINC ? 8'h11 : 8'h10), d: 8'hBB});
    wbyte(8'hBB, -1, ack); check("bw_ack", 32'(ack), 32'd0);
    i2c_stop();

    // Burst read
    i2c_start();
    wbyte(8'h42, -1, ack);
    wbyte(8'h20, -1, ack);
    i2c_start();
    wbyte(8'h43, -1, ack);
    rbyte(1'b0, rb); check("br_data0", 32'(rb), 32'(8'h20 ^ 8'h7C));
    check("br_busy", 32'(busy), 32'd1);
    rbyte(1'b1, rb); check("br_data1", 32'(rb), 32'((AINC ? 8'h21 : 8'h20) ^ 8'h7C));
    i2c_stop();

    // SCL glitch inside a data byte
    i2c_start();
    wbyte(8'h42, -1, ack);
    wbyte(8'h05, 6, ack);
    exp_q.push_back('{a: 8'h05, d: 8'hA5});
    wbyte(8'hA5, 4, ack); check("gl_ack", 32'(ack), 32'd0);
    i2c_stop();

    // Pointer-only write, then read back
    i2c_start();
    wbyte(8'h42, -1, ack);
    wbyte(8'h30, -1, ack);
    i2c_stop();
    i2c_start();
    wbyte(8'h43, -1, ack);
    check("po_rd_addr", 32'(rd_addr), 32'h30);
    rbyte(1'b1, rb); check("po_data", 32'(rb), 32'(8'h30 ^ 8'h7C));
    i2c_stop();

    // Reset during bit 4 of a data byte
    i2c_start();
    wbyte(8'h42, -1, ack);
    wbyte(8'h01, -1, ack);
    for (int i = 7; i >= 4; i--) wbit(8'h99 >> i, 1'b0);
    rst_pulse("rd_rst_sda");
    check("rd_rst_busy", 32'(busy), 32'd0);
    for (int i = 3; i >= 0; i--) wbit(8'h99 >> i, 1'b0);
    rbit(ack); check("rd_rst_nack", 32'(ack), 32'd1);
    i2c_stop();
    i2c_start();
    wbyte(8'h42, -1, ack); check("post_rst_ack", 32'(ack), 32'd0);
    wbyte(8'h01, -1, ack);
    exp_q.push_back('{a: 8'h01, d: 8'h55});
    wbyte(8'h55, -1, ack);
    i2c_stop();

    // Reset while the target is driving ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(8'h42 >> i, 1'b0);
    m_low = 1'b0;
    qwait(8);
    check("ack_driven", 32'(sda_bus), 32'd0);
    rst_pulse("ack_rst_sda");
    i2c_stop();

    qwait(20);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
